reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 25 ++
 rtl/rob_entry.sv | 73 +++++++
 rtl/reorder_buffer.sv | 97 +++++++++
 tb/tb_reorder_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: depths, widths, tag encoding
// and the per-entry lifecycle state.
package reorder_buffer_pkg;
  localparam int ROB_DEPTH      = 8;
  localparam int ROB_IDX_W      = 3;
  localparam int COUNT_W        = 4;
  localparam int REG_NUM_WIDTH  = 5;
  localparam int OP_TYPE_WIDTH  = 4;
  localparam int INST_TAG_WIDTH = 4;
  localparam int COMMON_WIDTH   = 32;

  // Reserved "no producer" tag; never handed out since tags are 0..7.
  localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = 4'hF;

  typedef enum logic [1:0] {
    ENT_EMPTY  = 2'd0,
    ENT_ISSUED = 2'd1,
    ENT_DONE   = 2'd2
  } ent_state_e;

  // Tags are the entry index zero-extended; the MSB is only set by TAG_INVALID.
  function automatic logic [INST_TAG_WIDTH-1:0] idx_to_tag(input logic [ROB_IDX_W-1:0] idx);
    return {1'b0, idx};
  endfunction
endpackage

// File: rtl/rob_entry.sv
// One reorder-buffer slot: lifecycle state, destination, op and result,
// plus the writeback tag match for this slot.
module rob_entry
  import reorder_buffer_pkg::*;
#(
  parameter logic [ROB_IDX_W-1:0] IDX = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc_we,
  input  logic [REG_NUM_WIDTH-1:0]  alloc_rd,
  input  logic [OP_TYPE_WIDTH-1:0]  alloc_op,
  input  logic                      commit_clr,
  input  logic                      wb_valid,
  input  logic [INST_TAG_WIDTH-1:0] wb_tag,
  input  logic [COMMON_WIDTH-1:0]   wb_val,
  output ent_state_e                state_o,
  output logic [REG_NUM_WIDTH-1:0]  rd_o,
  output logic [OP_TYPE_WIDTH-1:0]  op_o,
  output logic [COMMON_WIDTH-1:0]   val_o
);
  ent_state_e                state_q, state_d;
  logic [REG_NUM_WIDTH-1:0]  rd_q, rd_d;
  logic [OP_TYPE_WIDTH-1:0]  op_q, op_d;
  logic [COMMON_WIDTH-1:0]   val_q, val_d;
  logic                      wb_hit;

  // Only an ISSUED slot accepts a result; TAG_INVALID never equals a slot tag.
  assign wb_hit = wb_valid && (wb_tag == idx_to_tag(IDX)) && (state_q == ENT_ISSUED);

  // Next state: flush beats alloc, alloc beats writeback; commit and
  // writeback cannot both hit since they need DONE vs ISSUED.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    op_d    = op_q;
    val_d   = val_q;
    if (flush) begin
      state_d = ENT_EMPTY;
    end else if (alloc_we) begin
      state_d = ENT_ISSUED;
      rd_d    = alloc_rd;
      op_d    = alloc_op;
    end else begin
      if (commit_clr) state_d = ENT_EMPTY;
      if (wb_hit) begin
        state_d = ENT_DONE;
        val_d   = wb_val;
      end
    end
  end

  // Slot registers; reset clears payload so commit outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ENT_EMPTY;
      rd_q    <= '0;
      op_q    <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      val_q   <= val_d;
    end
  end

  assign state_o = state_q;
  assign rd_o    = rd_q;
  assign op_o    = op_q;
  assign val_o   = val_q;
endmodule

// File: rtl/reorder_buffer.sv
// 8-entry in-order-retire reorder buffer: allocates at tail, accepts
// out-of-order writebacks by tag, retires at most one DONE head per cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc_req,
  input  logic [REG_NUM_WIDTH-1:0]  alloc_rd,
  input  logic [OP_TYPE_WIDTH-1:0]  alloc_op,
  output logic [INST_TAG_WIDTH-1:0] avail_tag,
  output logic                      full,
  input  logic                      wb_valid,
  input  logic [INST_TAG_WIDTH-1:0] wb_tag,
  input  logic [COMMON_WIDTH-1:0]   wb_val,
  output logic                      commit_valid,
  output logic                      commit_we,
  output logic [REG_NUM_WIDTH-1:0]  commit_rd,
  output logic [COMMON_WIDTH-1:0]   commit_val,
  output logic [INST_TAG_WIDTH-1:0] commit_tag
);
  logic [ROB_IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [COUNT_W-1:0]       count_q, count_d;
  logic                     alloc_acc;

  ent_state_e               st_arr  [ROB_DEPTH];
  logic [REG_NUM_WIDTH-1:0] rd_arr  [ROB_DEPTH];
  logic [OP_TYPE_WIDTH-1:0] op_arr  [ROB_DEPTH];
  logic [COMMON_WIDTH-1:0]  val_arr [ROB_DEPTH];

  // No full bypass: a same-cycle commit does not free a slot for alloc.
  assign full         = (count_q == COUNT_W'(ROB_DEPTH));
  assign alloc_acc    = alloc_req && !full;
  assign avail_tag    = idx_to_tag(tail_q);

  assign commit_valid = (count_q != '0) && (st_arr[head_q] == ENT_DONE);
  assign commit_rd    = rd_arr[head_q];
  assign commit_val   = val_arr[head_q];
  assign commit_tag   = idx_to_tag(head_q);
  assign commit_we    = commit_valid && (commit_rd != '0);

  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_ent
    rob_entry #(.IDX(ROB_IDX_W'(i))) u_ent (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .alloc_we   (alloc_acc && (tail_q == ROB_IDX_W'(i))),
      .alloc_rd   (alloc_rd),
      .alloc_op   (alloc_op),
      .commit_clr (commit_valid && (head_q == ROB_IDX_W'(i))),
      .wb_valid   (wb_valid),
      .wb_tag     (wb_tag),
      .wb_val     (wb_val),
      .state_o    (st_arr[i]),
      .rd_o       (rd_arr[i]),
      .op_o       (op_arr[i]),
      .val_o      (val_arr[i])
    );
  end

  // Op type is held per entry for downstream consumers; commit does not use it.
  logic unused_op;
  always_comb begin
    unused_op = 1'b0;
    for (int i = 0; i < ROB_DEPTH; i++) unused_op = unused_op ^ (^op_arr[i]);
  end

  // Pointer/occupancy update; flush collapses the queue to empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_acc)    tail_d = tail_q + 1'b1;
      if (commit_valid) head_d = head_q + 1'b1;
      count_d = count_q + COUNT_W'(alloc_acc) - COUNT_W'(commit_valid);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected commits into a
// queue, a negedge monitor pops and checks every retirement.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      flush = 1'b0;
  logic                      alloc_req = 1'b0;
  logic [REG_NUM_WIDTH-1:0]  alloc_rd = '0;
  logic [OP_TYPE_WIDTH-1:0]  alloc_op = '0;
  logic [INST_TAG_WIDTH-1:0] avail_tag;
  logic                      full;
  logic                      wb_valid = 1'b0;
  logic [INST_TAG_WIDTH-1:0] wb_tag = '0;
  logic [COMMON_WIDTH-1:0]   wb_val = '0;
  logic                      commit_valid, commit_we;
  logic [REG_NUM_WIDTH-1:0]  commit_rd;
  logic [COMMON_WIDTH-1:0]   commit_val;
  logic [INST_TAG_WIDTH-1:0] commit_tag;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_req(alloc_req), .alloc_rd(alloc_rd), .alloc_op(alloc_op),
    .avail_tag(avail_tag), .full(full),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_val(commit_val), .commit_tag(commit_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [INST_TAG_WIDTH-1:0] tag;
    logic [REG_NUM_WIDTH-1:0]  rd;
  } exp_t;

  exp_t                    q[$];
  logic [COMMON_WIDTH-1:0] exp_val [16];
  logic [ROB_IDX_W-1:0]    m_tail = '0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; alloc_req = 1'b0; wb_valid = 1'b0;
    q.delete();
    m_tail = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [REG_NUM_WIDTH-1:0] rd);
    exp_t e;
    chk("avail_tag_pre_alloc", 32'(avail_tag), 32'({1'b0, m_tail}));
    alloc_req = 1'b1; alloc_rd = rd; alloc_op = rd[3:0];
    e.tag = {1'b0, m_tail};
    e.rd  = rd;
    q.push_back(e);
    m_tail = m_tail + 1'b1;
    step();
    alloc_req = 1'b0;
  endtask

  task automatic wb(input logic [INST_TAG_WIDTH-1:0] tag, input logic [COMMON_WIDTH-1:0] val);
    wb_valid = 1'b1; wb_tag = tag; wb_val = val;
    exp_val[tag] = val;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every retirement must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && commit_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_commit_tag", 32'(commit_tag), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("commit_tag", 32'(commit_tag), 32'(e.tag));
          chk("commit_rd",  32'(commit_rd),  32'(e.rd));
          chk("commit_val", commit_val,      exp_val[e.tag]);
          chk("commit_we",  32'(commit_we),  32'(e.rd != 0));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held
    #2;
    chk("rst_avail_tag",    32'(avail_tag),    0);
    chk("rst_full",         32'(full),         0);
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_commit_we",    32'(commit_we),    0);
    chk("rst_commit_rd",    32'(commit_rd),    0);
    chk("rst_commit_val",   commit_val,        0);
    chk("rst_commit_tag",   32'(commit_tag),   0);
    do_reset();

    // Two allocations
    alloc(5'd3);
    alloc(5'd5);
    chk("two_alloc_avail_tag", 32'(avail_tag), 2);
    chk("two_alloc_no_commit", 32'(commit_valid), 0);
    wb(4'd0, 32'hA0);
    wb(4'd1, 32'hA1);
    drain();

    // Fill to full, refused alloc, no bypass on commit
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 7));
    chk("fill_full", 32'(full), 1);
    chk("fill_avail_tag", 32'(avail_tag), 0);
    alloc_req = 1'b1; alloc_rd = 5'd30;
    step();
    chk("refused_avail_tag", 32'(avail_tag), 0);
    chk("refused_full", 32'(full), 1);
    wb_valid = 1'b1; wb_tag = 4'd0; wb_val = 32'h11; exp_val[0] = 32'h11;
    step();
    wb_valid = 1'b0;
    chk("full_commit_valid", 32'(commit_valid), 1);
    chk("full_commit_rd", 32'(commit_rd), 7);
    chk("full_commit_val", commit_val, 32'h11);
    chk("full_still_full", 32'(full), 1);
    step();
    alloc_req = 1'b0;
    chk("after_commit_full", 32'(full), 0);
    chk("no_bypass_avail_tag", 32'(avail_tag), 0);
    for (int i = 1; i < 8; i++) wb(4'(i), 32'h100 + 32'(i));
    drain();

    // Out-of-order completion, in-order retirement
    do_reset();
    alloc(5'd1); alloc(5'd2); alloc(5'd4);
    wb(4'd2, 32'hC2);
    chk("ooo_wait_a", 32'(commit_valid), 0);
    wb(4'd1, 32'hC1);
    chk("ooo_wait_b", 32'(commit_valid), 0);
    wb(4'd0, 32'hC0);
    for (int i = 0; i < 3; i++) begin
      chk("ooo_commit_valid", 32'(commit_valid), 1);
      chk("ooo_commit_tag", 32'(commit_tag), 32'(i));
      step();
    end
    chk("ooo_done", 32'(commit_valid), 0);
    drain();

    // Write to r0 retires without a register write
    do_reset();
    alloc(5'd0);
    wb(4'd0, 32'hDEAD);
    chk("r0_commit_valid", 32'(commit_valid), 1);
    chk("r0_commit_we", 32'(commit_we), 0);
    drain();

    // Wrap-around streams: batches of four, completed in reverse order
    do_reset();
    for (int b = 0; b < 5; b++) begin
      logic [INST_TAG_WIDTH-1:0] tags [4];
      for (int j = 0; j < 4; j++) begin
        tags[j] = {1'b0, m_tail};
        alloc(5'((b * 4 + j) * 3 + 1));
        repeat ($urandom_range(0, 2)) step();
      end
      for (int j = 3; j >= 0; j--) begin
        wb(tags[j], 32'h5000 + 32'(b * 16 + j));
        repeat ($urandom_range(0, 2)) step();
      end
    end
    drain();

    // Flush with five in flight plus a simultaneous alloc
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(i + 2));
    flush = 1'b1; alloc_req = 1'b1; alloc_rd = 5'd9;
    step();
    flush = 1'b0; alloc_req = 1'b0;
    q.delete();
    m_tail = '0;
    chk("flush_avail_tag", 32'(avail_tag), 0);
    chk("flush_full", 32'(full), 0);
    chk("flush_commit_valid", 32'(commit_valid), 0);
    wb(4'd3, 32'hBAD);
    chk("stale_wb_ignored", 32'(commit_valid), 0);
    for (int i = 0; i < 7; i++) alloc(5'(i + 10));
    chk("flush_count_7_not_full", 32'(full), 0);
    alloc(5'd17);
    chk("flush_count_8_full", 32'(full), 1);
    wb(TAG_INVALID, 32'hFFFF);
    chk("invalid_tag_ignored", 32'(commit_valid), 0);

    // Async reset mid-cycle with a commit pending
    wb_valid = 1'b1; wb_tag = 4'd0; wb_val = 32'h55; exp_val[0] = 32'h55;
    step();
    wb_valid = 1'b0;
    chk("pre_rst_commit_valid", 32'(commit_valid), 1);
    chk("pre_rst_full", 32'(full), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_commit_valid", 32'(commit_valid), 0);
    chk("async_rst_full", 32'(full), 0);
    chk("async_rst_avail_tag", 32'(avail_tag), 0);
    chk("async_rst_commit_val", commit_val, 0);
    q.delete();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle", 32'(commit_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
